// File: rtl/rmii_frame_gen.sv
// RMII receive-side frame generator: preamble, SFD, patterned payload, CRC-32 FCS
// and inter-frame gap, driven as LSB-first dibits at one dibit per 50 MHz cycle.
module rmii_frame_gen #(
  parameter int unsigned MIN_LEN   = 46,
  parameter int unsigned MAX_LEN   = 1500,
  parameter int unsigned IFG_BYTES = 12,
  parameter int unsigned LEN_W     = 11
) (
  input  logic             clk_50_mhz,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [1:0]       mode,
  input  logic [7:0]       seed,
  input  logic             inj_err,
  output logic             crs_dv,
  output logic [1:0]       rx_d,
  output logic             rx_er,
  output logic             busy,
  output logic             done,
  output logic [15:0]      frame_cnt
);
  localparam int unsigned GAP = IFG_BYTES * 4;
  localparam int unsigned GW  = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [2:0] {IDLE, PRE, SFD, PAY, FCS, IFG} state_t;

  state_t           state;
  logic [1:0]       dib;
  logic [LEN_W-1:0] bcnt, len_q, len_eff;
  logic [GW-1:0]    gcnt;
  logic [1:0]       mode_q;
  logic [7:0]       seed_q;
  logic             inj_q;
  logic [7:0]       byte_r;
  logic [31:0]      crc, fcs_val;

  logic             byte_end, state_end, gap_end, accept, load_pay;
  logic [7:0]       pay_first, pay_adv, pay_byte, fcs_byte, nxt_byte;
  logic [1:0]       rx_next;

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int unsigned i = 0; i < 8; i++)
      r = (r >> 1) ^ (((r[0] ^ d[i]) != 1'b0) ? 32'hEDB88320 : '0);
    return r;
  endfunction

  assign rx_er = 1'b0;

  always_comb begin
    len_eff = len;
    if (len < LEN_W'(MIN_LEN))      len_eff = LEN_W'(MIN_LEN);
    else if (len > LEN_W'(MAX_LEN)) len_eff = LEN_W'(MAX_LEN);

    byte_end  = (dib == 2'd3);
    state_end = 1'b0;
    case (state)
      PRE:     state_end = (bcnt == LEN_W'(6));
      SFD:     state_end = 1'b1;
      PAY:     state_end = (bcnt == len_q - LEN_W'(1));
      FCS:     state_end = (bcnt == LEN_W'(3));
      default: state_end = 1'b0;
    endcase
    gap_end = (state == IFG) && (gcnt == GW'(GAP - 1));
    accept  = start && ((state == IDLE) || gap_end);

    pay_first = ((mode_q == 2'd2) && (seed_q == 8'h00)) ? 8'h01 : seed_q;
    case (mode_q)
      2'd1:    pay_adv = byte_r;
      2'd2:    pay_adv = {byte_r[6:0], byte_r[7] ^ byte_r[5] ^ byte_r[4] ^ byte_r[3]};
      default: pay_adv = byte_r + 8'd1;
    endcase
    pay_byte = (state == SFD) ? pay_first : pay_adv;

    fcs_val = ~crc;
    case (bcnt[1:0])
      2'd0:    fcs_byte = fcs_val[15:8];
      2'd1:    fcs_byte = fcs_val[23:16];
      default: fcs_byte = fcs_val[31:24];
    endcase

    // Byte loaded at the last dibit of the current one; CRC advances only on payload loads
    nxt_byte = 8'h55;
    load_pay = 1'b0;
    case (state)
      PRE: nxt_byte = state_end ? 8'hD5 : 8'h55;
      SFD: begin
        nxt_byte = pay_byte;
        load_pay = 1'b1;
      end
      PAY: begin
        nxt_byte = state_end ? (fcs_val[7:0] ^ {7'b0, inj_q}) : pay_byte;
        load_pay = !state_end;
      end
      FCS:     nxt_byte = fcs_byte;
      default: nxt_byte = 8'h55;
    endcase

    case (dib)
      2'd0:    rx_next = byte_r[3:2];
      2'd1:    rx_next = byte_r[5:4];
      default: rx_next = byte_r[7:6];
    endcase
  end

  always_ff @(posedge clk_50_mhz or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      dib       <= '0;
      bcnt      <= '0;
      gcnt      <= '0;
      len_q     <= '0;
      mode_q    <= '0;
      seed_q    <= '0;
      inj_q     <= 1'b0;
      byte_r    <= '0;
      crc       <= '1;
      crs_dv    <= 1'b0;
      rx_d      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      frame_cnt <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        state  <= PRE;
        dib    <= '0;
        bcnt   <= '0;
        gcnt   <= '0;
        len_q  <= len_eff;
        mode_q <= mode;
        seed_q <= seed;
        inj_q  <= inj_err;
        byte_r <= 8'h55;
        crc    <= '1;
        crs_dv <= 1'b1;
        rx_d   <= 2'b01;
        busy   <= 1'b1;
      end else begin
        case (state)
          PRE, SFD, PAY, FCS: begin
            dib <= dib + 2'd1;
            if (!byte_end) begin
              rx_d <= rx_next;
            end else if (state == FCS && state_end) begin
              state  <= IFG;
              crs_dv <= 1'b0;
              rx_d   <= '0;
              gcnt   <= '0;
            end else begin
              byte_r <= nxt_byte;
              rx_d   <= nxt_byte[1:0];
              if (load_pay) crc <= crc_upd(crc, nxt_byte);
              if (state_end) begin
                bcnt <= '0;
                case (state)
                  PRE:     state <= SFD;
                  SFD:     state <= PAY;
                  default: state <= FCS;
                endcase
              end else begin
                bcnt <= bcnt + LEN_W'(1);
              end
            end
          end
          IFG: begin
            if (gap_end) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              gcnt <= gcnt + GW'(1);
              if (gcnt == GW'(GAP - 2)) begin
                done      <= 1'b1;
                frame_cnt <= frame_cnt + 16'd1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_rmii_frame_gen.sv
// Directed bench for rmii_frame_gen: captures dibit streams and checks framing,
// payload patterns, CRC-32, gap timing, reset abort and back-to-back operation.
module tb_rmii_frame_gen;
  logic        clk_50_mhz = 1'b0;
  logic        rst_n = 1'b0, start = 1'b0, inj_err = 1'b0;
  logic [10:0] len = '0;
  logic [1:0]  mode = '0;
  logic [7:0]  seed = '0;
  logic        crs_dv, rx_er, busy, done;
  logic [1:0]  rx_d;
  logic [15:0] frame_cnt;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] rxb [0:2047];
  int nbytes, ncrs, nbusy, ndone, nerr, fin;

  rmii_frame_gen #(.MIN_LEN(46), .MAX_LEN(1500), .IFG_BYTES(12), .LEN_W(11)) dut (
    .clk_50_mhz(clk_50_mhz), .rst_n(rst_n), .start(start), .len(len), .mode(mode),
    .seed(seed), .inj_err(inj_err), .crs_dv(crs_dv), .rx_d(rx_d), .rx_er(rx_er),
    .busy(busy), .done(done), .frame_cnt(frame_cnt)
  );

  always #10 clk_50_mhz = ~clk_50_mhz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = r ^ {31'b0, d[i]};
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  function automatic logic [7:0] exp_pay(input logic [1:0] m, input logic [7:0] s, input int k);
    logic [7:0] v;
    case (m)
      2'd1: return s;
      2'd2: begin
        v = (s == 8'h00) ? 8'h01 : s;
        for (int i = 0; i < k; i++) v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
        return v;
      end
      default: return s + 8'(k);
    endcase
  endfunction

  // Samples every cycle from the one after the accepting edge until busy falls.
  task automatic capture(input int poke_at);
    int dcnt;
    logic [7:0] cur;
    ncrs = 0; nbusy = 0; ndone = 0; nerr = 0; nbytes = 0; fin = 0;
    dcnt = 0; cur = '0;
    for (int c = 0; c < 8000; c++) begin
      @(negedge clk_50_mhz);
      if (c == 0) start = 1'b0;
      if (c == poke_at) start = 1'b1;
      else if (c == poke_at + 1) start = 1'b0;
      if (rx_er !== 1'b0) nerr++;
      if (!crs_dv && rx_d !== 2'b00) nerr++;
      if (done) ndone++;
      if (crs_dv) begin
        ncrs++;
        cur = cur | ({6'b0, rx_d} << (2 * dcnt));
        dcnt++;
        if (dcnt == 4) begin
          rxb[nbytes] = cur;
          nbytes++;
          cur = '0;
          dcnt = 0;
        end
      end
      if (busy) nbusy++;
      else begin
        fin = 1;
        break;
      end
    end
    chk("capture_terminates", fin, 1);
  endtask

  task automatic send(input logic [10:0] l, input logic [1:0] m, input logic [7:0] s,
                      input logic inj, input int poke_at);
    @(negedge clk_50_mhz);
    len = l; mode = m; seed = s; inj_err = inj; start = 1'b1;
    capture(poke_at);
  endtask

  task automatic check_frame(input string tag, input int l, input logic [1:0] m,
                             input logic [7:0] s, input logic inj);
    int bad;
    logic [31:0] c, fcs;
    logic [7:0] e;
    chk($sformatf("%s crs_cycles", tag), ncrs, (12 + l) * 4);
    chk($sformatf("%s busy_cycles", tag), nbusy, (24 + l) * 4);
    chk($sformatf("%s done_pulses", tag), ndone, 1);
    chk($sformatf("%s rx_er_or_idle_rx_d", tag), nerr, 0);
    bad = 0;
    for (int i = 0; i < 7; i++) if (rxb[i] !== 8'h55) bad++;
    if (rxb[7] !== 8'hD5) bad++;
    chk($sformatf("%s preamble_sfd_bad", tag), bad, 0);
    bad = 0;
    c = 32'hFFFFFFFF;
    for (int k = 0; k < l; k++) begin
      e = exp_pay(m, s, k);
      if (rxb[8 + k] !== e) bad++;
      c = crc_byte(c, e);
    end
    chk($sformatf("%s payload_bad", tag), bad, 0);
    c = ~c;
    c[0] = c[0] ^ inj;
    fcs = {rxb[8 + l + 3], rxb[8 + l + 2], rxb[8 + l + 1], rxb[8 + l]};
    chk($sformatf("%s fcs", tag), fcs, c);
  endtask

  initial begin
    int g1, g2, ngaps, gap, nfr, busylow, seen, prev;

    repeat (3) @(negedge clk_50_mhz);
    chk("reset crs_dv", crs_dv, 0);
    chk("reset rx_d", rx_d, 0);
    chk("reset rx_er", rx_er, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset frame_cnt", frame_cnt, 0);
    rst_n = 1'b1;
    @(negedge clk_50_mhz);

    send(11'd10, 2'd0, 8'h00, 1'b0, 100);
    check_frame("A", 46, 2'd0, 8'h00, 1'b0);
    chk("A last_payload", rxb[8 + 45], 8'h2D);
    chk("A frame_cnt", frame_cnt, 1);
    repeat (10) @(negedge clk_50_mhz);
    chk("A no_queued_frame", busy, 0);

    send(11'd2000, 2'd0, 8'h00, 1'b0, -5);
    check_frame("B", 1500, 2'd0, 8'h00, 1'b0);
    chk("B last_payload", rxb[8 + 1499], 8'hDB);
    chk("B frame_cnt", frame_cnt, 2);

    send(11'd46, 2'd2, 8'h00, 1'b0, -5);
    check_frame("C", 46, 2'd2, 8'h00, 1'b0);
    chk("C lfsr_byte0", rxb[8], 8'h01);

    send(11'd60, 2'd1, 8'hA5, 1'b1, -5);
    check_frame("D", 60, 2'd1, 8'hA5, 1'b1);
    send(11'd60, 2'd1, 8'hA5, 1'b0, -5);
    check_frame("E", 60, 2'd1, 8'hA5, 1'b0);

    send(11'd50, 2'd3, 8'hF0, 1'b0, -5);
    check_frame("F", 50, 2'd3, 8'hF0, 1'b0);
    chk("F frame_cnt", frame_cnt, 6);

    // Abort mid-payload with an asynchronous reset
    @(negedge clk_50_mhz);
    len = 11'd46; mode = 2'd0; seed = 8'h07; inj_err = 1'b0; start = 1'b1;
    @(negedge clk_50_mhz);
    start = 1'b0;
    repeat (60) @(negedge clk_50_mhz);
    chk("G in_frame", crs_dv, 1);
    #5 rst_n = 1'b0;
    #1;
    chk("G abort crs_dv", crs_dv, 0);
    chk("G abort rx_d", rx_d, 0);
    chk("G abort busy", busy, 0);
    chk("G abort done", done, 0);
    chk("G abort frame_cnt", frame_cnt, 0);
    @(negedge clk_50_mhz);
    rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk_50_mhz);
      if (done) ndone++;
    end
    chk("G no_done_after_abort", ndone, 0);
    chk("G frame_cnt_after_abort", frame_cnt, 0);
    send(11'd46, 2'd0, 8'h07, 1'b0, -5);
    check_frame("H", 46, 2'd0, 8'h07, 1'b0);
    chk("H frame_cnt", frame_cnt, 1);

    // Back-to-back frames with start held high
    @(negedge clk_50_mhz);
    rst_n = 1'b0;
    @(negedge clk_50_mhz);
    rst_n = 1'b1;
    @(negedge clk_50_mhz);
    len = 11'd46; mode = 2'd0; seed = 8'h3C; inj_err = 1'b0; start = 1'b1;
    g1 = 0; g2 = 0; ngaps = 0; gap = 0; nfr = 0; busylow = 0; seen = 0; prev = 0;
    ndone = 0; fin = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk_50_mhz);
      if (done) begin
        ndone++;
        if (ndone == 3) start = 1'b0;
      end
      if (crs_dv) begin
        if (prev == 0) nfr++;
        if (seen != 0 && gap > 0) begin
          if (ngaps == 0) g1 = gap; else g2 = gap;
          ngaps++;
        end
        gap = 0;
        seen = 1;
      end else if (seen != 0) begin
        gap++;
      end
      prev = crs_dv ? 1 : 0;
      if (!busy && ndone < 3) busylow++;
      if (ndone == 3 && !busy) begin
        fin = 1;
        break;
      end
    end
    chk("I terminates", fin, 1);
    chk("I frames", nfr, 3);
    chk("I gaps", ngaps, 2);
    chk("I gap1_cycles", g1, 48);
    chk("I gap2_cycles", g2, 48);
    chk("I busy_dropped", busylow, 0);
    chk("I frame_cnt", frame_cnt, 3);
    repeat (20) @(negedge clk_50_mhz);
    chk("I no_fourth_frame", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/rmii_frame_gen.md
RMII_FRAME_GEN -- requirements
Module: rmii_frame_gen

Interface
REQ-001 SHALL have parameter MIN_LEN, default 46: minimum payload bytes; shorter requests are padded up to it.
REQ-002 SHALL have parameter MAX_LEN, default 1500: maximum payload bytes; longer requests are clamped to it.
REQ-003 SHALL have parameter IFG_BYTES, default 12: inter-frame gap in byte times.
REQ-004 SHALL have parameter LEN_W, default 11: width of len.
REQ-005 SHALL have port clk_50_mhz, input, 1: sole clock, RMII reference.
REQ-006 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port start, input, 1: frame request, sampled on a rising edge.
REQ-008 SHALL have port len, input, LEN_W: requested payload byte count.
REQ-009 SHALL have port mode, input, 2: payload pattern select.
REQ-010 SHALL have port seed, input, 8: pattern seed.
REQ-011 SHALL have port inj_err, input, 1: corrupt the FCS of this frame.
REQ-012 SHALL have port crs_dv, output, 1: RMII carrier/data valid.
REQ-013 SHALL have port rx_d, output, 2: RMII dibit.
REQ-014 SHALL have port rx_er, output, 1: RMII receive error; always 0 in this revision.
REQ-015 SHALL have port busy, output, 1: frame or gap in progress.
REQ-016 SHALL have port done, output, 1: one-cycle pulse at end of gap.
REQ-017 SHALL have port frame_cnt, output, 16: count of completed frames.

Function
REQ-018 SHALL implement states IDLE, PRE, SFD, PAY, FCS, IFG; each byte SHALL occupy 4 cycles, dibits LSB first (bits[1:0] first).
REQ-019 IDLE->PRE SHALL occur when start=1 in IDLE; len, mode, seed and inj_err SHALL be latched on that edge.
REQ-020 The first preamble dibit SHALL appear on rx_d with crs_dv=1 in the cycle after the sampling edge.
REQ-021 start while busy=1 SHALL be ignored, with no queuing.
REQ-022 Effective length L SHALL be: MIN_LEN if len<MIN_LEN; MAX_LEN if len>MAX_LEN; otherwise len.
REQ-023 PRE SHALL send 7 bytes 0x55, then move to SFD.
REQ-024 SFD SHALL send 1 byte 0xD5, then move to PAY.
REQ-025 PAY SHALL send L bytes, then move to FCS.
REQ-026 FCS SHALL send 4 bytes, then move to IFG.
REQ-027 IFG SHALL hold crs_dv=0 and rx_d=00 for IFG_BYTES*4 cycles, then move to IDLE.
REQ-028 Payload byte k (0-based) SHALL follow mode: 0 = (seed+k) mod 256; 1 = seed constant; 2 = 8-bit Fibonacci LFSR x^8+x^6+x^5+x^4+1, byte 0 = seed (seed 0 replaced by 0x01), advanced once per byte; 3 = same as mode 0.
REQ-029 FCS SHALL be CRC-32 IEEE 802.3, reflected, init 0xFFFFFFFF, over payload bytes only, final XOR 0xFFFFFFFF, sent low byte first.
REQ-030 When inj_err was latched as 1, bit 0 of the first FCS byte SHALL be inverted.
REQ-031 crs_dv SHALL be 1 from the first preamble dibit through the last FCS dibit inclusive, and 0 otherwise.
REQ-032 busy SHALL be 1 from the cycle after the accepting edge until done, inclusive; total busy cycles = (8+L+4+IFG_BYTES)*4.
REQ-033 done SHALL pulse for 1 cycle, the last IFG cycle.
REQ-034 frame_cnt SHALL increment by 1 in the same cycle as done, wrapping 0xFFFF->0x0000.
REQ-035 start held high continuously SHALL start a new frame on the edge following done, giving back-to-back frames separated by exactly IFG_BYTES bytes.

Reset
REQ-036 rst_n=0 SHALL immediately force: state IDLE, crs_dv=0, rx_d=00, rx_er=0, busy=0, done=0, frame_cnt=0, CRC=0xFFFFFFFF, internal counters 0.
REQ-037 Reset asserted mid-frame SHALL abort the frame immediately, with no done pulse and no frame_cnt increment.
REQ-038 After rst_n deasserts, the first accepted start SHALL produce a complete, correct frame.

Verification
REQ-039 len=10, mode=0, seed=0x00 -> L=46; crs_dv high 232 cycles; payload 0x00..0x2D; FCS matches software CRC model; busy 280 cycles; frame_cnt=1.
REQ-040 len=2000 -> L=1500; crs_dv high 6048 cycles; last payload byte (mode 0, seed 0) = 0xDB.
REQ-041 mode=2, seed=0x00 -> payload byte 0 = 0x01; subsequent bytes match LFSR model; FCS correct.
REQ-042 inj_err=1 -> FCS differs from correct value only in bit 0 of first FCS byte; next frame with inj_err=0 is correct.
REQ-043 start held high for 3 frames -> exactly 48 idle cycles between frames; frame_cnt=3; extra start pulses during busy ignored.
REQ-044 rst_n pulsed low during PAY -> outputs reset within the same cycle; no done; frame_cnt=0; next frame correct.
